spi_ram_responder: RTL and testbench

- Synthesizable SPI mode-0 target that emulates the serial RAM behind the SoC memory controller's shared SPI bus (ram_cs_n, spi_sclk, spi_mosi, spi_miso).
- Used for FPGA bring-up and for closed-loop simulation of the controller without an external part.
- Oversamples the SPI pins in the system clock domain and decodes READ (0x03) and WRITE (0x02) with a 24-bit address.
- Backs these commands with an internal byte array; addresses auto-increment during a burst.

---
 rtl/spi_ram_pkg.sv | 32 +++
 rtl/spi_pin_sync.sv | 62 ++++++
 rtl/spi_ram_responder.sv | 222 ++++++++++++++++++++++
 tb/tb_spi_ram_responder.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// rtl/spi_ram_pkg.sv - shared constants and types for the SPI serial-RAM responder
//
// Purpose: opcode constants, address framing and FSM state encoding shared by
// the responder top level.
//   OP_READ / OP_WRITE : supported command opcodes
//   ADDR_BYTES         : address bytes following the opcode
//   ADDR_BITS          : address bits shifted in after the opcode
//   CNT_W              : width of the serial bit counter (covers ADDR_BITS)
//   state_t            : responder FSM states
package spi_ram_pkg;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;

    localparam int ADDR_BYTES = 3;
    localparam int ADDR_BITS  = ADDR_BYTES * 8;
    localparam int CNT_W      = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_RD,
        ST_WR,
        ST_IGNORE
    } state_t;

    function automatic logic is_supported_op(input logic [7:0] op);
        return (op == OP_READ) || (op == OP_WRITE);
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - SPI pin synchronizer and edge-strobe generator
//
// Purpose: brings cs_n, sclk and mosi into the clk domain and produces
// one-cycle edge strobes. mosi is delayed by the same amount as the sclk
// strobes so that mosi_s is the bit to sample in a sclk_rise cycle.
// Pin-to-strobe delay is SYNC_STAGES+1 clk.
// Ports:
//   clk, rst              : system clock, synchronous active-high reset
//   cs_n, sclk, mosi      : raw asynchronous SPI pins
//   cs_fall, cs_rise      : one-cycle chip-select edge strobes
//   sclk_rise, sclk_fall  : one-cycle SPI clock edge strobes
//   mosi_s                : synchronized mosi aligned with the strobes
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic cs_n,
    input  logic sclk,
    input  logic mosi,
    output logic cs_fall,
    output logic cs_rise,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic mosi_s
);

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   cs_last;
    logic                   sclk_last;

    // Reset values model an idle bus (cs_n high, sclk low) so that leaving
    // reset never produces a spurious edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_last   <= 1'b1;
            sclk_last <= 1'b0;
            cs_fall   <= 1'b0;
            cs_rise   <= 1'b0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            mosi_s    <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            cs_last   <= cs_sync[SYNC_STAGES-1];
            sclk_last <= sclk_sync[SYNC_STAGES-1];
            cs_fall   <= cs_last & ~cs_sync[SYNC_STAGES-1];
            cs_rise   <= ~cs_last & cs_sync[SYNC_STAGES-1];
            sclk_rise <= ~sclk_last & sclk_sync[SYNC_STAGES-1];
            sclk_fall <= sclk_last & ~sclk_sync[SYNC_STAGES-1];
            mosi_s    <= mosi_sync[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/spi_ram_responder.sv
// rtl/spi_ram_responder.sv - SPI mode-0 serial RAM target with internal byte array
//
// Purpose: decodes READ (0x03) / WRITE (0x02) with a 24-bit address and
// serves them from an internal byte array; addresses auto-increment and wrap
// at MEM_BYTES. Upper address bits alias.
// Ports:
//   clk, rst     : system clock (>= 8x sclk), synchronous active-high reset
//   spi_cs_n     : chip select, active low
//   spi_sclk     : SPI clock, mode 0
//   spi_mosi     : serial data in, MSB first
//   spi_miso     : serial data out, MSB first
//   spi_miso_oe  : tristate enable, high while serving read data
//   cmd_err      : one-cycle pulse on an unsupported opcode
//   xfer_active  : high while a transaction is in progress
module spi_ram_responder #(
    parameter int MEM_BYTES   = 8192,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic spi_cs_n,
    input  logic spi_sclk,
    input  logic spi_mosi,
    output logic spi_miso,
    output logic spi_miso_oe,
    output logic cmd_err,
    output logic xfer_active
);

    import spi_ram_pkg::*;

    localparam int                AW            = $clog2(MEM_BYTES);
    localparam logic [AW-1:0]     ADDR_ONE      = AW'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0]  LAST_BYTE_BIT = CNT_W'(7);
    localparam logic [CNT_W-1:0]  LAST_ADDR_BIT = CNT_W'(ADDR_BITS - 1);

    logic cs_fall;
    logic cs_rise;
    logic sclk_rise;
    logic sclk_fall;
    logic mosi_s;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic [7:0]       rx_shift;
    logic [7:0]       rx_byte;
    logic [AW-1:0]    addr;
    logic [AW-1:0]    addr_next;
    logic             is_read;
    logic [7:0]       rd_byte;
    logic [2:0]       rd_cnt;
    logic             miso_q;
    logic             cmd_err_q;
    logic             byte_done;
    logic             addr_done;
    logic             mem_we;

    logic [7:0] mem [0:MEM_BYTES-1];

    spi_pin_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_pin_sync (
        .clk       (clk),
        .rst       (rst),
        .cs_n      (spi_cs_n),
        .sclk      (spi_sclk),
        .mosi      (spi_mosi),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .mosi_s    (mosi_s)
    );

    // Byte including the bit arriving this cycle; only the low AW address
    // bits are kept, which makes the upper address bits alias.
    assign rx_byte   = {rx_shift[6:0], mosi_s};
    assign addr_next = {addr[AW-2:0], mosi_s};
    assign byte_done = sclk_rise && (bit_cnt == LAST_BYTE_BIT);
    assign addr_done = sclk_rise && (bit_cnt == LAST_ADDR_BIT);
    // cs_rise wins over a coincident sclk_rise, so a partial byte is dropped.
    assign mem_we    = (state == ST_WR) && byte_done && !cs_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state != ST_IDLE && cs_rise) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_nxt = ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (byte_done) begin
                        state_nxt = is_supported_op(rx_byte) ? ST_ADDR : ST_IGNORE;
                    end
                end
                ST_ADDR: begin
                    if (addr_done) begin
                        state_nxt = is_read ? ST_RD : ST_WR;
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end
    end

    always_comb begin
        spi_miso_oe = 1'b0;
        xfer_active = 1'b0;
        spi_miso    = miso_q;
        cmd_err     = cmd_err_q;
        if (state == ST_RD) begin
            spi_miso_oe = 1'b1;
        end
        if (state != ST_IDLE) begin
            xfer_active = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            rx_shift  <= '0;
            addr      <= '0;
            is_read   <= 1'b0;
            rd_byte   <= '0;
            rd_cnt    <= '0;
            miso_q    <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            cmd_err_q <= 1'b0;
            if (cs_rise) begin
                bit_cnt <= '0;
                rd_cnt  <= '0;
                miso_q  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        bit_cnt <= '0;
                        rd_cnt  <= '0;
                        miso_q  <= 1'b0;
                    end
                    ST_CMD: begin
                        if (sclk_rise) begin
                            rx_shift <= rx_byte;
                            bit_cnt  <= bit_cnt + CNT_ONE;
                            if (byte_done) begin
                                bit_cnt   <= '0;
                                is_read   <= (rx_byte == OP_READ);
                                cmd_err_q <= !is_supported_op(rx_byte);
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (sclk_rise) begin
                            addr    <= addr_next;
                            bit_cnt <= bit_cnt + CNT_ONE;
                            if (addr_done) begin
                                bit_cnt <= '0;
                                // Fetch the first byte now and point at the
                                // following one so later bytes stream gapless.
                                if (is_read) begin
                                    rd_byte <= mem[addr_next];
                                    addr    <= addr_next + ADDR_ONE;
                                    rd_cnt  <= '0;
                                end
                            end
                        end
                    end
                    ST_RD: begin
                        if (sclk_fall) begin
                            miso_q <= rd_byte[~rd_cnt];
                            rd_cnt <= rd_cnt + 3'd1;
                            // bit0 is already in miso_q, so the next byte can
                            // replace rd_byte in the same cycle.
                            if (rd_cnt == 3'd7) begin
                                rd_byte <= mem[addr];
                                addr    <= addr + ADDR_ONE;
                            end
                        end
                    end
                    ST_WR: begin
                        if (sclk_rise) begin
                            rx_shift <= rx_byte;
                            bit_cnt  <= bit_cnt + CNT_ONE;
                            if (byte_done) begin
                                bit_cnt <= '0;
                                addr    <= addr + ADDR_ONE;
                            end
                        end
                    end
                    default: begin
                        bit_cnt <= '0;
                    end
                endcase
            end
        end
    end

    // Contents survive reset; only writes are blocked while rst is high.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[addr] <= rx_byte;
        end
    end

endmodule

// File: tb/tb_spi_ram_responder.sv
// tb/tb_spi_ram_responder.sv - self-checking bench for spi_ram_responder
module tb_spi_ram_responder;

    localparam int MEM = 8192;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spi_cs_n = 1'b1;
    logic spi_sclk = 1'b0;
    logic spi_mosi = 1'b0;
    logic spi_miso;
    logic spi_miso_oe;
    logic cmd_err;
    logic xfer_active;

    int n_pass = 0;
    int n_total = 0;
    int half_clks = 8;
    int err_cycles = 0;
    int oe_cycles = 0;

    logic [7:0] model_mem [0:MEM-1];
    bit         known     [0:MEM-1];
    logic [7:0] wbuf [0:15];
    logic [7:0] rbuf [0:15];

    spi_ram_responder #(
        .MEM_BYTES   (MEM),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .spi_cs_n    (spi_cs_n),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .cmd_err     (cmd_err),
        .xfer_active (xfer_active)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_err) err_cycles++;
        if (spi_miso_oe) oe_cycles++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic int wrap(input int a);
        return a & (MEM - 1);
    endfunction

    task automatic spi_bit(input logic mo, output logic mi);
        spi_mosi = mo;
        repeat (half_clks) @(negedge clk);
        mi = spi_miso;
        spi_sclk = 1'b1;
        repeat (half_clks) @(negedge clk);
        spi_sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], b);
            rx[i] = b;
        end
    endtask

    task automatic cs_begin();
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (half_clks) @(negedge clk);
    endtask

    task automatic cs_end();
        repeat (half_clks) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (4 * half_clks + 4) @(negedge clk);
    endtask

    task automatic send_header(input logic [7:0] op, input logic [23:0] a);
        logic [7:0] d;
        spi_byte(op, d);
        spi_byte(a[23:16], d);
        spi_byte(a[15:8], d);
        spi_byte(a[7:0], d);
    endtask

    task automatic ram_write(input logic [23:0] a, input int n);
        logic [7:0] d;
        cs_begin();
        send_header(8'h02, a);
        for (int i = 0; i < n; i++) begin
            spi_byte(wbuf[i], d);
            model_mem[wrap(int'(a) + i)] = wbuf[i];
            known[wrap(int'(a) + i)] = 1'b1;
        end
        cs_end();
    endtask

    task automatic ram_read(input logic [23:0] a, input int n);
        logic [7:0] d;
        cs_begin();
        send_header(8'h03, a);
        for (int i = 0; i < n; i++) begin
            spi_byte(8'h00, d);
            rbuf[i] = d;
        end
        cs_end();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        if (spi_miso !== 1'b0) begin $display("FAIL reset_miso: got %b want 0", spi_miso); end else n_pass++;
        n_total++;
        if (spi_miso_oe !== 1'b0) begin $display("FAIL reset_oe: got %b want 0", spi_miso_oe); end else n_pass++;
        n_total++;
        if (cmd_err !== 1'b0) begin $display("FAIL reset_cmd_err: got %b want 0", cmd_err); end else n_pass++;
        n_total++;
        if (xfer_active !== 1'b0) begin $display("FAIL reset_xfer_active: got %b want 0", xfer_active); end else n_pass++;
        n_total++;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        if (xfer_active !== 1'b0) begin $display("FAIL post_reset_idle: got %b want 0", xfer_active); end else n_pass++;
        n_total++;
    endtask

    task automatic test_basic(input string tag);
        logic [7:0] expv [0:3];
        int e0;
        expv[0] = 8'hDE; expv[1] = 8'hAD; expv[2] = 8'hBE; expv[3] = 8'hEF;
        for (int i = 0; i < 4; i++) wbuf[i] = expv[i];
        e0 = err_cycles;
        ram_write(24'h000010, 4);
        ram_read(24'h000010, 4);
        for (int i = 0; i < 4; i++) begin
            if (rbuf[i] !== expv[i]) $display("FAIL %s_rd%0d: got %02h want %02h", tag, i, rbuf[i], expv[i]);
            else n_pass++;
            n_total++;
        end
        if (err_cycles - e0 != 0) $display("FAIL %s_cmd_err: got %0d pulses want 0", tag, err_cycles - e0);
        else n_pass++;
        n_total++;
    endtask

    task automatic test_wrap();
        logic [7:0] expv [0:3];
        expv[0] = 8'h11; expv[1] = 8'h22; expv[2] = 8'h33; expv[3] = 8'h44;
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        ram_write(24'h001FFE, 2);
        wbuf[0] = 8'h33; wbuf[1] = 8'h44;
        ram_write(24'h000000, 2);
        ram_read(24'h001FFE, 4);
        for (int i = 0; i < 4; i++) begin
            if (rbuf[i] !== expv[i]) $display("FAIL wrap_rd%0d: got %02h want %02h", i, rbuf[i], expv[i]);
            else n_pass++;
            n_total++;
        end
    endtask

    task automatic test_alias();
        wbuf[0] = 8'h5A;
        ram_write(24'h00A005, 1);
        ram_read(24'h000005, 1);
        if (rbuf[0] !== 8'h5A) $display("FAIL alias_rd: got %02h want 5a", rbuf[0]);
        else n_pass++;
        n_total++;
    endtask

    task automatic test_bad_opcode();
        logic [7:0] d;
        logic [7:0] junk [0:5];
        int e0, o0;
        junk[0] = 8'h9F; junk[1] = 8'h02; junk[2] = 8'h00;
        junk[3] = 8'h00; junk[4] = 8'h30; junk[5] = 8'h77;
        wbuf[0] = 8'h66;
        ram_write(24'h000030, 1);
        e0 = err_cycles;
        o0 = oe_cycles;
        cs_begin();
        if (xfer_active !== 1'b1) $display("FAIL bad_op_xfer_active: got %b want 1", xfer_active);
        else n_pass++;
        n_total++;
        for (int i = 0; i < 6; i++) spi_byte(junk[i], d);
        cs_end();
        if (err_cycles - e0 != 1) $display("FAIL bad_op_err_pulse: got %0d cycles want 1", err_cycles - e0);
        else n_pass++;
        n_total++;
        if (oe_cycles - o0 != 0) $display("FAIL bad_op_oe: got %0d oe cycles want 0", oe_cycles - o0);
        else n_pass++;
        n_total++;
        if (xfer_active !== 1'b0) $display("FAIL bad_op_end_idle: got %b want 0", xfer_active);
        else n_pass++;
        n_total++;
        ram_read(24'h000030, 1);
        if (rbuf[0] !== 8'h66) $display("FAIL bad_op_ignored_data: got %02h want 66", rbuf[0]);
        else n_pass++;
        n_total++;
    endtask

    task automatic test_partial_write();
        logic [7:0] d;
        logic b;
        wbuf[0] = 8'h99;
        ram_write(24'h000021, 1);
        cs_begin();
        send_header(8'h02, 24'h000020);
        spi_byte(8'hAB, d);
        model_mem[16'h20] = 8'hAB;
        known[16'h20] = 1'b1;
        spi_bit(1'b1, b); spi_bit(1'b1, b); spi_bit(1'b0, b); spi_bit(1'b0, b);
        cs_end();
        ram_read(24'h000020, 2);
        if (rbuf[0] !== 8'hAB) $display("FAIL partial_full_byte: got %02h want ab", rbuf[0]);
        else n_pass++;
        n_total++;
        if (rbuf[1] !== 8'h99) $display("FAIL partial_dropped: got %02h want 99", rbuf[1]);
        else n_pass++;
        n_total++;
    endtask

    task automatic test_random();
        logic [23:0] a;
        int n;
        for (int it = 0; it < 8; it++) begin
            a = 24'($urandom);
            n = int'($urandom_range(1, 8));
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            ram_write(a, n);
            ram_read(a, n);
            for (int i = 0; i < n; i++) begin
                if (rbuf[i] !== model_mem[wrap(int'(a) + i)])
                    $display("FAIL rand%0d_rd%0d @%06h: got %02h want %02h", it, i, a, rbuf[i], model_mem[wrap(int'(a) + i)]);
                else n_pass++;
                n_total++;
            end
        end
        // earlier fixed locations must still match the model after random traffic
        ram_read(24'h000010, 4);
        for (int i = 0; i < 4; i++) begin
            if (known[16 + i]) begin
                if (rbuf[i] !== model_mem[16 + i])
                    $display("FAIL retain_rd%0d: got %02h want %02h", i, rbuf[i], model_mem[16 + i]);
                else n_pass++;
                n_total++;
            end
        end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] d;
        logic b;
        for (int i = 0; i < 3; i++) wbuf[i] = 8'hFF;
        wbuf[1] = 8'hF0;
        ram_write(24'h000040, 3);
        cs_begin();
        send_header(8'h03, 24'h000040);
        spi_byte(8'h00, d);
        if (d !== model_mem[16'h40]) $display("FAIL midrd_first: got %02h want %02h", d, model_mem[16'h40]);
        else n_pass++;
        n_total++;
        spi_bit(1'b0, b); spi_bit(1'b0, b); spi_bit(1'b0, b);
        if (spi_miso_oe !== 1'b1 || spi_miso !== 1'b1)
            $display("FAIL midrd_driving: got oe=%b miso=%b want oe=1 miso=1", spi_miso_oe, spi_miso);
        else n_pass++;
        n_total++;
        rst = 1'b1;
        @(negedge clk);
        if (spi_miso !== 1'b0 || spi_miso_oe !== 1'b0 || xfer_active !== 1'b0)
            $display("FAIL midrd_reset: got miso=%b oe=%b xa=%b want 0 0 0", spi_miso, spi_miso_oe, xfer_active);
        else n_pass++;
        n_total++;
        rst = 1'b0;
        spi_cs_n = 1'b1;
        repeat (4 * half_clks + 8) @(negedge clk);
        ram_read(24'h000040, 3);
        for (int i = 0; i < 3; i++) begin
            if (rbuf[i] !== model_mem[16'h40 + i])
                $display("FAIL midrd_retained%0d: got %02h want %02h", i, rbuf[i], model_mem[16'h40 + i]);
            else n_pass++;
            n_total++;
        end
    endtask

    initial begin
        test_reset();
        test_basic("basic");
        test_wrap();
        test_alias();
        test_bad_opcode();
        test_partial_write();
        test_random();
        test_reset_mid_read();
        half_clks = 4;
        test_basic("ratio8");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
